// File: rtl/multicycle_cpu.sv
// Multicycle 4-register CPU: FETCH/DECODE/EXEC/WB sequencing over a 16-bit instruction word.
// Instruction memory is external with a ready handshake; registers are readable via a debug port.
module multicycle_cpu #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned IMEM_AW = 10
) (
    input  logic               clock,
    input  logic               resetn,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ready,
    input  logic [15:0]        imem_data,
    output logic [IMEM_AW-1:0] pc,
    output logic [15:0]        ir,
    output logic [DATA_W-1:0]  alu_out,
    output logic               zero,
    output logic               wb_valid,
    output logic               halted,
    input  logic [1:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StWb, StHalt} state_e;

    state_e             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q;
    logic [15:0]        ir_q;
    logic [DATA_W-1:0]  rf_q [4];
    logic [DATA_W-1:0]  opa_q, opb_q, alu_q, alu_res;
    logic               taken_q;

    logic [3:0]         op;
    logic [1:0]         rs, rt, rd, dest;
    logic [DATA_W-1:0]  imm_ext;
    logic [IMEM_AW-1:0] pc_inc, pc_target;
    logic               is_rtype, is_addi, is_beq, is_bne, wb_en, eq;

    assign op        = ir_q[15:12];
    assign rs        = ir_q[11:10];
    assign rt        = ir_q[9:8];
    assign rd        = ir_q[7:6];
    assign imm_ext   = DATA_W'($signed(ir_q[7:0]));
    assign is_rtype  = (op <= 4'h4) || (op == 4'h6);
    assign is_addi   = (op == 4'h7);
    assign is_beq    = (op == 4'h8);
    assign is_bne    = (op == 4'h9);
    assign dest      = is_addi ? rt : rd;
    // r0 is hard-wired: a write to it is dropped and never reported
    assign wb_en     = (is_rtype || is_addi) && (dest != 2'd0);
    assign eq        = (opa_q == opb_q);
    assign pc_inc    = pc_q + IMEM_AW'(1);
    assign pc_target = pc_inc + IMEM_AW'($signed(ir_q[7:0]));

    always_comb begin
        unique case (op)
            4'h0:    alu_res = opa_q + opb_q;
            4'h1:    alu_res = opa_q - opb_q;
            4'h2:    alu_res = opa_q & opb_q;
            4'h3:    alu_res = opa_q | opb_q;
            4'h4:    alu_res = ~(opa_q | opb_q);
            4'h6:    alu_res = {{(DATA_W-1){1'b0}}, $signed(opa_q) < $signed(opb_q)};
            4'h7:    alu_res = opa_q + imm_ext;
            4'h8,
            4'h9:    alu_res = opa_q - opb_q;
            default: alu_res = opa_q + opb_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        wb_valid = 1'b0;
        halted   = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req = resetn;
                if (imem_ready) state_d = StDecode;
            end
            StDecode: state_d = (op == 4'hf) ? StHalt : StExec;
            StExec:   state_d = StWb;
            StWb: begin
                wb_valid = wb_en;
                state_d  = StFetch;
            end
            StHalt:   halted = 1'b1;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StFetch;
            pc_q    <= '0;
            ir_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            alu_q   <= '0;
            taken_q <= 1'b0;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StFetch: if (imem_ready) ir_q <= imem_data;
                StDecode: begin
                    opa_q <= rf_q[rs];
                    opb_q <= rf_q[rt];
                end
                StExec: begin
                    alu_q   <= alu_res;
                    taken_q <= (is_beq && eq) || (is_bne && !eq);
                end
                StWb: begin
                    if (wb_en) rf_q[dest] <= alu_q;
                    pc_q <= taken_q ? pc_target : pc_inc;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign alu_out   = alu_q;
    assign zero      = (alu_q == '0);
    assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed bench for multicycle_cpu: a 16-bit instance for the main program, wait states,
// branches and reset, plus a 32-bit instance for wide arithmetic and pc wrap on branches.
module tb_multicycle_cpu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic        rst16 = 1'b0, ready16 = 1'b1;
    logic        req16, zero16, wbv16, halt16;
    logic [9:0]  addr16, pc16;
    logic [15:0] ir16, data16, alu16, dbgd16;
    logic [1:0]  dbga16 = 2'd0;
    logic [15:0] mem16 [1024];
    assign data16 = mem16[addr16];

    logic        rst32 = 1'b0, ready32 = 1'b1;
    logic        req32, zero32, wbv32, halt32;
    logic [9:0]  addr32, pc32;
    logic [15:0] ir32, data32;
    logic [31:0] alu32, dbgd32;
    logic [1:0]  dbga32 = 2'd0;
    logic [15:0] mem32 [1024];
    assign data32 = mem32[addr32];

    multicycle_cpu #(.DATA_W(16), .IMEM_AW(10)) dut16 (
        .clock(clock), .resetn(rst16), .imem_req(req16), .imem_addr(addr16),
        .imem_ready(ready16), .imem_data(data16), .pc(pc16), .ir(ir16), .alu_out(alu16),
        .zero(zero16), .wb_valid(wbv16), .halted(halt16), .dbg_addr(dbga16), .dbg_data(dbgd16)
    );

    multicycle_cpu #(.DATA_W(32), .IMEM_AW(10)) dut32 (
        .clock(clock), .resetn(rst32), .imem_req(req32), .imem_addr(addr32),
        .imem_ready(ready32), .imem_data(data32), .pc(pc32), .ir(ir32), .alu_out(alu32),
        .zero(zero32), .wb_valid(wbv32), .halted(halt32), .dbg_addr(dbga32), .dbg_data(dbgd32)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rd16(input logic [1:0] a, output logic [15:0] v);
        dbga16 = a;
        #1;
        v = dbgd16;
    endtask

    task automatic rd32(input logic [1:0] a, output logic [31:0] v);
        dbga32 = a;
        #1;
        v = dbgd32;
    endtask

    // Hold reset for two cycles and release just after a falling edge.
    task automatic reset16();
        rst16   = 1'b0;
        ready16 = 1'b1;
        step(2);
        @(negedge clock);
        rst16 = 1'b1;
        #1;
    endtask

    task automatic load_main16();
        for (int i = 0; i < 1024; i++) mem16[i] = 16'hF000;
        mem16[0] = 16'h710F;  // addi r1,r0,15
        mem16[1] = 16'h7207;  // addi r2,r0,7
        mem16[2] = 16'h26C0;  // and  r3,r1,r2
        mem16[3] = 16'h1780;  // sub  r2,r1,r3
        mem16[4] = 16'h3B80;  // or   r2,r2,r3
        mem16[5] = 16'h0BC0;  // add  r3,r2,r3
        mem16[6] = 16'h4B40;  // nor  r1,r2,r3
        mem16[7] = 16'h6E40;  // slt  r1,r3,r2
        mem16[8] = 16'h6B40;  // slt  r1,r2,r3
        mem16[9] = 16'hF000;  // halt
    endtask

    task automatic test_reset();
        logic [15:0] v;
        rst16 = 1'b0;
        #3;
        checks++; if (pc16 !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0h exp 0", pc16); end
        checks++; if (ir16 !== 16'd0) begin errors++; $display("FAIL reset_ir: got %0h exp 0", ir16); end
        checks++; if (alu16 !== 16'd0) begin errors++; $display("FAIL reset_alu: got %0h exp 0", alu16); end
        checks++; if (zero16 !== 1'b1) begin errors++; $display("FAIL reset_zero: got %0b exp 1", zero16); end
        checks++; if (req16 !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b exp 0", req16); end
        checks++; if (wbv16 !== 1'b0) begin errors++; $display("FAIL reset_wbv: got %0b exp 0", wbv16); end
        checks++; if (halt16 !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b exp 0", halt16); end
        for (int r = 0; r < 4; r++) begin
            rd16(2'(r), v);
            checks++; if (v !== 16'd0) begin errors++; $display("FAIL reset_r%0d: got %0h exp 0", r, v); end
        end
    endtask

    task automatic test_program();
        logic [1:0]  dst [9] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd1, 2'd1, 2'd1};
        logic [15:0] val [9] = '{16'd15, 16'd7, 16'd7, 16'd8, 16'd15, 16'd22, 16'hFFE0,
                                 16'd0, 16'd1};
        logic [15:0] v;
        load_main16();
        reset16();
        checks++; if (req16 !== 1'b1 || addr16 !== 10'd0) begin
            errors++; $display("FAIL release_fetch: req=%0b addr=%0h exp req=1 addr=0", req16, addr16);
        end
        step(1);
        checks++; if (ir16 !== 16'h710F) begin errors++; $display("FAIL ir_latch: got %0h exp 710f", ir16); end
        checks++; if (req16 !== 1'b0) begin errors++; $display("FAIL req_decode: got %0b exp 0", req16); end
        step(2);
        for (int i = 0; i < 9; i++) begin
            if (i != 0) step(3);
            checks++; if (wbv16 !== 1'b1) begin
                errors++; $display("FAIL prog_wbv[%0d]: got %0b exp 1", i, wbv16);
            end
            step(1);
            rd16(dst[i], v);
            checks++; if (v !== val[i]) begin
                errors++; $display("FAIL prog_r%0d[%0d]: got %0h exp %0h", dst[i], i, v, val[i]);
            end
            if (i == 7) begin
                checks++; if (alu16 !== 16'd0 || zero16 !== 1'b1) begin
                    errors++; $display("FAIL slt_zero: alu=%0h zero=%0b exp alu=0 zero=1", alu16, zero16);
                end
            end
        end
        step(1);  // edge 37
        checks++; if (halt16 !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b exp 0", halt16); end
        step(1);  // edge 38
        checks++; if (halt16 !== 1'b1) begin errors++; $display("FAIL halt_38: got %0b exp 1", halt16); end
        step(5);
        checks++; if (halt16 !== 1'b1 || req16 !== 1'b0 || pc16 !== 10'd9) begin
            errors++; $display("FAIL halt_hold: halted=%0b req=%0b pc=%0h exp 1 0 9", halt16, req16, pc16);
        end
        rd16(2'd1, v);
        checks++; if (v !== 16'd1) begin errors++; $display("FAIL halt_r1: got %0h exp 1", v); end
    endtask

    task automatic test_wait_states();
        logic [15:0] v;
        load_main16();
        reset16();
        step(8);
        checks++; if (pc16 !== 10'd2) begin errors++; $display("FAIL ws_pc: got %0h exp 2", pc16); end
        ready16 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++; if (req16 !== 1'b1 || addr16 !== 10'd2) begin
                errors++; $display("FAIL ws_hold[%0d]: req=%0b addr=%0h exp req=1 addr=2", k, req16, addr16);
            end
        end
        ready16 = 1'b1;
        step(3);
        checks++; if (wbv16 !== 1'b1) begin errors++; $display("FAIL ws_wbv: got %0b exp 1", wbv16); end
        rd16(2'd3, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL ws_early: got %0h exp 0", v); end
        step(1);
        rd16(2'd3, v);
        checks++; if (v !== 16'd7) begin errors++; $display("FAIL ws_r3: got %0h exp 7", v); end
        checks++; if (pc16 !== 10'd3) begin errors++; $display("FAIL ws_pc_after: got %0h exp 3", pc16); end
    endtask

    task automatic test_branches();
        logic [15:0] v;
        for (int i = 0; i < 1024; i++) mem16[i] = 16'hF000;
        mem16[0] = 16'h7105;  // addi r1,r0,5
        mem16[1] = 16'h7205;  // addi r2,r0,5
        mem16[2] = 16'h7005;  // addi r0,r0,5
        mem16[3] = 16'h9605;  // bne  r1,r2,+5
        mem16[4] = 16'h86FE;  // beq  r1,r2,-2
        reset16();
        step(8);
        rd16(2'd2, v);
        checks++; if (v !== 16'd5) begin errors++; $display("FAIL br_r2: got %0h exp 5", v); end
        step(3);
        checks++; if (wbv16 !== 1'b0) begin errors++; $display("FAIL r0_wbv: got %0b exp 0", wbv16); end
        step(1);
        rd16(2'd0, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL r0_read: got %0h exp 0", v); end
        checks++; if (alu16 !== 16'd5) begin errors++; $display("FAIL r0_alu: got %0h exp 5", alu16); end
        step(3);
        checks++; if (wbv16 !== 1'b0) begin errors++; $display("FAIL bne_wbv: got %0b exp 0", wbv16); end
        step(1);
        checks++; if (pc16 !== 10'd4) begin errors++; $display("FAIL bne_pc: got %0h exp 4", pc16); end
        step(3);
        checks++; if (wbv16 !== 1'b0) begin errors++; $display("FAIL beq_wbv: got %0b exp 0", wbv16); end
        step(1);
        checks++; if (pc16 !== 10'd3) begin errors++; $display("FAIL beq_pc: got %0h exp 3", pc16); end
        rd16(2'd1, v);
        checks++; if (v !== 16'd5) begin errors++; $display("FAIL br_r1: got %0h exp 5", v); end
    endtask

    task automatic test_reset_mid_exec();
        logic [15:0] v;
        load_main16();
        reset16();
        step(6);
        checks++; if (alu16 !== 16'd15 || pc16 !== 10'd1) begin
            errors++; $display("FAIL mid_pre: alu=%0h pc=%0h exp alu=f pc=1", alu16, pc16);
        end
        #2;
        rst16 = 1'b0;
        #1;
        checks++; if (alu16 !== 16'd0 || pc16 !== 10'd0 || ir16 !== 16'd0) begin
            errors++; $display("FAIL mid_async: alu=%0h pc=%0h ir=%0h exp 0 0 0", alu16, pc16, ir16);
        end
        checks++; if (req16 !== 1'b0 || wbv16 !== 1'b0 || halt16 !== 1'b0) begin
            errors++; $display("FAIL mid_ctrl: req=%0b wbv=%0b halted=%0b exp 0 0 0", req16, wbv16, halt16);
        end
        rd16(2'd1, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL mid_r1: got %0h exp 0", v); end
        step(2);
        @(negedge clock);
        rst16 = 1'b1;
        #1;
        checks++; if (req16 !== 1'b1 || addr16 !== 10'd0) begin
            errors++; $display("FAIL mid_restart: req=%0b addr=%0h exp req=1 addr=0", req16, addr16);
        end
        step(4);
        rd16(2'd1, v);
        checks++; if (v !== 16'd15) begin errors++; $display("FAIL mid_rerun_r1: got %0h exp f", v); end
        rd16(2'd2, v);
        checks++; if (v !== 16'd0) begin errors++; $display("FAIL mid_rerun_r2: got %0h exp 0", v); end
    endtask

    task automatic test_wide();
        logic [31:0] v;
        for (int i = 0; i < 1024; i++) mem32[i] = 16'hF000;
        mem32[0] = 16'h71FF;  // addi r1,r0,-1
        mem32[1] = 16'h0580;  // add  r2,r1,r1
        mem32[2] = 16'h64C0;  // slt  r3,r1,r0
        mem32[3] = 16'h80FB;  // beq  r0,r0,-5 -> wraps to 1023
        rst32 = 1'b0;
        step(2);
        @(negedge clock);
        rst32 = 1'b1;
        #1;
        step(4);
        rd32(2'd1, v);
        checks++; if (v !== 32'hFFFFFFFF) begin errors++; $display("FAIL w_r1: got %0h exp ffffffff", v); end
        step(3);
        checks++; if (alu32 !== 32'hFFFFFFFE || zero32 !== 1'b0) begin
            errors++; $display("FAIL w_alu: alu=%0h zero=%0b exp fffffffe 0", alu32, zero32);
        end
        step(1);
        rd32(2'd2, v);
        checks++; if (v !== 32'hFFFFFFFE) begin errors++; $display("FAIL w_r2: got %0h exp fffffffe", v); end
        step(4);
        rd32(2'd3, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL w_r3: got %0h exp 1", v); end
        step(4);
        checks++; if (pc32 !== 10'h3FF) begin errors++; $display("FAIL w_pc_wrap: got %0h exp 3ff", pc32); end
        step(2);
        checks++; if (halt32 !== 1'b1) begin errors++; $display("FAIL w_halt: got %0b exp 1", halt32); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem16[i] = 16'hF000;
            mem32[i] = 16'hF000;
        end
        test_reset();
        test_program();
        test_wait_states();
        test_branches();
        test_reset_mid_exec();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
